// File: rtl/fir_mc.sv
// Multi-channel serial FIR: private circular delay line per channel, one
// shared runtime-programmable coefficient set, one MAC per tap per cycle.
//
// state  | meaning
// S_IDLE | waiting for a sample; coefficient writes accepted
// S_MAC  | accumulating tap tap_q of channel ch_q
module fir_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int NUM_TAPS   = 8,
    parameter int NUM_CH     = 2,
    parameter int OUT_SHIFT  = 7,
    localparam int TW = $clog2(NUM_TAPS),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] xin_i,
    input  logic [CW-1:0]         ch_in_i,
    input  logic                  we_i,
    input  logic                  coef_we_i,
    input  logic [TW-1:0]         coef_addr_i,
    input  logic [COEF_WIDTH-1:0] coef_data_i,
    output logic                  running_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] xout_o,
    output logic [CW-1:0]         xout_ch_o,
    output logic                  sat_o,
    output logic                  err_o
);

    localparam int PW      = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W   = PW + TW;
    localparam int RND_INT = (2 ** OUT_SHIFT) / 2;

    typedef enum logic {S_IDLE, S_MAC} state_t;

    state_t                        state_q;
    logic signed [DATA_WIDTH-1:0]  dline_q [NUM_CH][NUM_TAPS];
    logic        [TW-1:0]          wptr_q  [NUM_CH];
    logic signed [COEF_WIDTH-1:0]  coef_q  [NUM_TAPS];
    logic        [CW-1:0]          ch_q;
    logic        [TW-1:0]          tap_q;
    logic        [TW-1:0]          rd_q;
    logic signed [ACC_W-1:0]       acc_q;
    logic                          running_q;
    logic                          done_q;
    logic        [DATA_WIDTH-1:0]  xout_q;
    logic        [CW-1:0]          xout_ch_q;
    logic                          sat_q;
    logic                          err_q;

    logic signed [DATA_WIDTH-1:0]  tap_x;
    logic signed [COEF_WIDTH-1:0]  tap_c;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_W-1:0]       acc_d;
    logic signed [ACC_W:0]         rnd;
    logic signed [ACC_W:0]         shifted;
    logic        [ACC_W-DATA_WIDTH+1:0] hi;
    logic                          sat_d;
    logic        [DATA_WIDTH-1:0]  res_d;
    logic                          ch_ok;
    logic                          addr_ok;

    function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
        return (p == TW'(NUM_TAPS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [TW-1:0] ptr_dec(input logic [TW-1:0] p);
        return (p == '0) ? TW'(NUM_TAPS - 1) : p - 1'b1;
    endfunction

    assign ch_ok   = ({1'b0, ch_in_i} < (CW + 1)'(NUM_CH));
    assign addr_ok = ({1'b0, coef_addr_i} < (TW + 1)'(NUM_TAPS));

    // rd_q walks backwards from the newest sample, so tap k sees x[n-k]
    always_comb begin
        tap_x   = dline_q[ch_q][rd_q];
        tap_c   = coef_q[tap_q];
        prod    = PW'(tap_x) * PW'(tap_c);
        acc_d   = acc_q + ACC_W'(prod);
        rnd     = (ACC_W + 1)'(acc_d) + (ACC_W + 1)'(RND_INT);
        shifted = rnd >>> OUT_SHIFT;
        hi      = shifted[ACC_W:DATA_WIDTH-1];
        sat_d   = !((&hi) || !(|hi));
        res_d   = shifted[DATA_WIDTH-1:0];
        if (sat_d) begin
            res_d = shifted[ACC_W] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            tap_q     <= '0;
            rd_q      <= '0;
            acc_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            xout_q    <= '0;
            xout_ch_q <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                for (int t = 0; t < NUM_TAPS; t++) begin
                    dline_q[c][t] <= '0;
                end
            end
            // c[0] = 1.0 in output scaling, i.e. unity passthrough
            for (int t = 0; t < NUM_TAPS; t++) begin
                coef_q[t] <= (t == 0) ? COEF_WIDTH'(2 ** OUT_SHIFT) : '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (we_i) begin
                        if (ch_ok) begin
                            dline_q[ch_in_i][wptr_q[ch_in_i]] <= xin_i;
                            wptr_q[ch_in_i] <= ptr_inc(wptr_q[ch_in_i]);
                            rd_q      <= wptr_q[ch_in_i];
                            ch_q      <= ch_in_i;
                            acc_q     <= '0;
                            tap_q     <= '0;
                            running_q <= 1'b1;
                            state_q   <= S_MAC;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (coef_we_i) begin
                        if (addr_ok) begin
                            coef_q[coef_addr_i] <= coef_data_i;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (we_i || coef_we_i) begin
                        err_q <= 1'b1;
                    end
                    acc_q <= acc_d;
                    tap_q <= tap_q + 1'b1;
                    rd_q  <= ptr_dec(rd_q);
                    if (tap_q == TW'(NUM_TAPS - 1)) begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        xout_q    <= res_d;
                        xout_ch_q <= ch_q;
                        sat_q     <= sat_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign running_o = running_q;
    assign done_o    = done_q;
    assign xout_o    = xout_q;
    assign xout_ch_o = xout_ch_q;
    assign sat_o     = sat_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc: directed samples push expected results, a
// negedge monitor pops and compares on every done; a 3-tap/3-channel copy covers range errors.
module tb_fir_mc;

    logic       clk;
    logic       reset;

    logic [7:0] xin;
    logic [0:0] ch_in;
    logic       we;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_data;
    logic       running;
    logic       done;
    logic signed [7:0] xout;
    logic [0:0] xout_ch;
    logic       sat;
    logic       err;

    logic [7:0] e_xin;
    logic [1:0] e_ch;
    logic       e_we;
    logic       e_cwe;
    logic [1:0] e_caddr;
    logic [7:0] e_cdata;
    logic       e_running;
    logic       e_done;
    logic signed [7:0] e_xout;
    logic [1:0] e_xout_ch;
    logic       e_sat;
    logic       e_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int xout;
        int ch;
        bit sat;
    } exp_t;
    exp_t sb[$];

    fir_mc #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(4), .NUM_CH(2), .OUT_SHIFT(6)) u_dut (
        .clk_i(clk), .reset_i(reset), .xin_i(xin), .ch_in_i(ch_in), .we_i(we),
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
        .running_o(running), .done_o(done), .xout_o(xout), .xout_ch_o(xout_ch),
        .sat_o(sat), .err_o(err)
    );

    fir_mc #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(3), .NUM_CH(3), .OUT_SHIFT(6)) u_edut (
        .clk_i(clk), .reset_i(reset), .xin_i(e_xin), .ch_in_i(e_ch), .we_i(e_we),
        .coef_we_i(e_cwe), .coef_addr_i(e_caddr), .coef_data_i(e_cdata),
        .running_o(e_running), .done_o(e_done), .xout_o(e_xout), .xout_ch_o(e_xout_ch),
        .sat_o(e_sat), .err_o(e_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with xout=%0d, expected no result", xout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("xout", int'(xout), e.xout);
                chk("xout_ch", int'(xout_ch), e.ch);
                chk("sat", int'(sat), int'(e.sat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no done, expected done within 20 cycles", name);
        end
    endtask

    task automatic set_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = 8'(data);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        set_coef(0, c0);
        set_coef(1, c1);
        set_coef(2, c2);
        set_coef(3, c3);
    endtask

    task automatic send(input int ch, input int x, input int exp, input bit s);
        sb.push_back('{xout: exp, ch: ch, sat: s});
        we    = 1'b1;
        ch_in = 1'(ch);
        xin   = 8'(x);
        @(negedge clk);
        we = 1'b0;
        wait_done("send_done");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic e_wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (e_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no done, expected done within 20 cycles", name);
        end
    endtask

    initial begin
        reset = 1'b1; xin = '0; ch_in = '0; we = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        e_xin = '0; e_ch = '0; e_we = 1'b0; e_cwe = 1'b0; e_caddr = '0; e_cdata = '0;
        do_reset();

        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xout", int'(xout), 0);
        chk("rst_xout_ch", int'(xout_ch), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_err", int'(err), 0);

        // passthrough and exact timing
        sb.push_back('{xout: -100, ch: 0, sat: 1'b0});
        we = 1'b1; ch_in = 1'b0; xin = 8'(-100);
        @(negedge clk);
        we = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            chk($sformatf("running_c%0d", n), int'(running), (n <= 4) ? 1 : 0);
            chk($sformatf("done_c%0d", n), int'(done), (n == 5) ? 1 : 0);
            @(negedge clk);
        end

        // moving sum
        do_reset();
        load4(16, 16, 16, 16);
        send(0, 40, 10, 0);
        send(0, 80, 30, 0);
        send(0, 120, 60, 0);
        send(0, -40, 50, 0);

        // channel isolation
        do_reset();
        load4(16, 16, 16, 16);
        send(0, 100, 25, 0);
        send(1, -60, -15, 0);
        send(0, 100, 50, 0);

        // saturation and rounding
        do_reset();
        load4(64, 64, 64, 64);
        send(1, 100, 100, 0);
        send(1, 100, 127, 1);
        send(1, -128, 72, 0);
        send(1, -128, -56, 0);
        send(1, -128, -128, 1);
        send(1, -128, -128, 1);
        load4(32, 0, 0, 0);
        send(0, 3, 2, 0);
        send(0, -3, -1, 0);

        // we during MAC is ignored
        do_reset();
        sb.push_back('{xout: 10, ch: 0, sat: 1'b0});
        we = 1'b1; ch_in = 1'b0; xin = 8'd10;
        @(negedge clk);
        we = 1'b1; ch_in = 1'b1; xin = 8'd99;
        @(negedge clk);
        we = 1'b0;
        wait_done("we_in_mac_done");
        idle_cycles(8);
        chk("we_in_mac_err", int'(err), 1);
        chk("we_in_mac_xout_hold", int'(xout), 10);
        send(1, 0, 0, 0);

        // coef_we during MAC is ignored
        do_reset();
        chk("err_cleared", int'(err), 0);
        sb.push_back('{xout: 50, ch: 0, sat: 1'b0});
        we = 1'b1; ch_in = 1'b0; xin = 8'd50;
        @(negedge clk);
        we = 1'b0;
        set_coef(0, 16);
        wait_done("coef_in_mac_done");
        chk("coef_in_mac_err", int'(err), 1);
        send(0, 20, 20, 0);

        // coefficient and sample in the same idle cycle
        do_reset();
        sb.push_back('{xout: 5, ch: 0, sat: 1'b0});
        we = 1'b1; ch_in = 1'b0; xin = 8'd10;
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd32;
        @(negedge clk);
        we = 1'b0; coef_we = 1'b0;
        wait_done("same_cycle_done");
        chk("same_cycle_err", int'(err), 0);

        // reset during the second MAC cycle
        do_reset();
        set_coef(1, 64);
        we = 1'b1; ch_in = 1'b0; xin = 8'd50;
        @(negedge clk);
        we = 1'b0;
        coef_we = 1'b1; coef_addr = 2'd2; coef_data = 8'd9;
        @(negedge clk);
        coef_we = 1'b0;
        chk("pre_abort_err", int'(err), 1);
        chk("pre_abort_running", int'(running), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_running", int'(running), 0);
        chk("abort_err", int'(err), 0);
        reset = 1'b0;
        idle_cycles(8);
        send(0, 7, 7, 0);
        send(0, 7, 7, 0);

        // out-of-range channel and coefficient address
        do_reset();
        chk("e_rst_err", int'(e_err), 0);
        e_we = 1'b1; e_ch = 2'd3; e_xin = 8'd50;
        @(negedge clk);
        e_we = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (e_done || e_running) seen++;
                @(negedge clk);
            end
            chk("bad_ch_no_activity", seen, 0);
        end
        chk("bad_ch_err", int'(e_err), 1);
        do_reset();
        e_cwe = 1'b1; e_caddr = 2'd3; e_cdata = 8'd5;
        @(negedge clk);
        e_cwe = 1'b0;
        chk("bad_addr_err", int'(e_err), 1);
        e_we = 1'b1; e_ch = 2'd2; e_xin = 8'd7;
        @(negedge clk);
        e_we = 1'b0;
        e_wait_done("e_done");
        chk("e_xout", int'(e_xout), 7);
        chk("e_xout_ch", int'(e_xout_ch), 2);

        idle_cycles(4);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
